// File: rtl/dram_responder_if.sv
// dram_responder_if: per-core DRAM request/response bus between the core array and the responder
interface dram_responder_if #(
    parameter int NUM_CORES = 4
);
    logic [2*NUM_CORES-1:0]  i_dram_read;
    logic [2*NUM_CORES-1:0]  i_dram_write;
    logic [16*NUM_CORES-1:0] i_dram_addr;
    logic [8*NUM_CORES-1:0]  i_dram_wdata;
    logic [8*NUM_CORES-1:0]  o_dram_rdata;
    logic [NUM_CORES-1:0]    o_ready;

    modport master (
        output i_dram_read, i_dram_write, i_dram_addr, i_dram_wdata,
        input  o_dram_rdata, o_ready
    );

    modport slave (
        input  i_dram_read, i_dram_write, i_dram_addr, i_dram_wdata,
        output o_dram_rdata, o_ready
    );
endinterface

// File: rtl/dram_responder.sv
// dram_responder: round-robin shared byte memory serving NUM_CORES cores plus a host preload port
module dram_responder #(
    parameter int NUM_CORES = 4,
    parameter int ADDR_W    = 12
) (
    input  logic            i_clk,
    input  logic            i_rst_n,
    dram_responder_if.slave bus,
    input  logic            i_load_en,
    input  logic [15:0]     i_load_addr,
    input  logic [7:0]      i_load_data,
    output logic            o_busy,
    output logic            o_err
);
    localparam int IDX_W = NUM_CORES > 1 ? $clog2(NUM_CORES) : 1;

    typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

    state_t               state;
    logic [7:0]           mem [2**ADDR_W];
    logic [NUM_CORES-1:0] valid, illegal, is_write, ready_q;
    logic [ADDR_W-1:0]    req_addr [NUM_CORES];
    logic [7:0]           req_wdata [NUM_CORES];
    logic [7:0]           rdata_q [NUM_CORES];
    logic [IDX_W-1:0]     last_grant, g_q, cand, gnt_idx;
    logic                 gnt_any, op_wr;
    logic [ADDR_W-1:0]    addr_q;
    logic [7:0]           wdata_q;
    logic                 unused_bits;

    // Address bits above ADDR_W are deliberately dropped so addresses wrap
    assign unused_bits = ^{i_load_addr, bus.i_dram_addr};

    for (genvar k = 0; k < NUM_CORES; k++) begin : g_core
        logic [1:0] rd, wr;
        assign rd                         = bus.i_dram_read[2*k +: 2];
        assign wr                         = bus.i_dram_write[2*k +: 2];
        assign valid[k]                   = (rd == 2'b01 && wr == 2'b00) || (rd == 2'b00 && wr == 2'b01);
        assign illegal[k]                 = rd[1] | wr[1] | (rd[0] & wr[0]);
        assign is_write[k]                = wr[0];
        assign req_addr[k]                = bus.i_dram_addr[16*k +: ADDR_W];
        assign req_wdata[k]               = bus.i_dram_wdata[8*k +: 8];
        assign bus.o_dram_rdata[8*k +: 8] = rdata_q[k];
    end

    assign bus.o_ready = ready_q;

    // Scan downward so the candidate closest to last_grant+1 is the one left standing
    always_comb begin
        gnt_any = 1'b0;
        gnt_idx = '0;
        cand    = '0;
        for (int i = NUM_CORES; i >= 1; i--) begin
            cand = IDX_W'((int'(last_grant) + i) % NUM_CORES);
            if (valid[cand]) begin
                gnt_any = 1'b1;
                gnt_idx = cand;
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state      <= IDLE;
            last_grant <= IDX_W'(NUM_CORES - 1);
            g_q        <= '0;
            op_wr      <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
            ready_q    <= '0;
            o_busy     <= 1'b0;
            o_err      <= 1'b0;
            for (int k = 0; k < NUM_CORES; k++) rdata_q[k] <= '0;
        end else begin
            if (|illegal) o_err <= 1'b1;
            case (state)
                IDLE: if (!i_load_en && gnt_any) begin
                    state   <= ACCESS;
                    g_q     <= gnt_idx;
                    op_wr   <= is_write[gnt_idx];
                    addr_q  <= req_addr[gnt_idx];
                    wdata_q <= req_wdata[gnt_idx];
                    o_busy  <= 1'b1;
                end
                ACCESS: begin
                    if (!op_wr) rdata_q[g_q] <= mem[addr_q];
                    ready_q <= NUM_CORES'(1) << g_q;
                    state   <= DONE;
                end
                DONE: begin
                    ready_q    <= '0;
                    last_grant <= g_q;
                    o_busy     <= 1'b0;
                    state      <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Array is not reset; a reset before the ACCESS edge leaves state in IDLE and suppresses the write
    always_ff @(posedge i_clk) begin
        if (i_rst_n && state == IDLE && i_load_en) mem[i_load_addr[ADDR_W-1:0]] <= i_load_data;
        else if (i_rst_n && state == ACCESS && op_wr) mem[addr_q] <= wdata_q;
    end
endmodule

// File: tb/tb_dram_responder.sv
// tb_dram_responder: directed scenario bench for dram_responder with hand-computed expectations
module tb_dram_responder;
    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        load_en;
    logic [15:0] load_addr;
    logic [7:0]  load_data;
    logic        busy, err;
    int          vectors = 0;
    int          miscompares = 0;

    dram_responder_if #(.NUM_CORES(4)) bus ();

    dram_responder #(.NUM_CORES(4), .ADDR_W(12)) dut (
        .i_clk       (clk),
        .i_rst_n     (rst_n),
        .bus         (bus.slave),
        .i_load_en   (load_en),
        .i_load_addr (load_addr),
        .i_load_data (load_data),
        .o_busy      (busy),
        .o_err       (err)
    );

    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int k, input logic [1:0] rd, input logic [1:0] wr,
                           input logic [15:0] a, input logic [7:0] d);
        bus.i_dram_read[2*k +: 2]   = rd;
        bus.i_dram_write[2*k +: 2]  = wr;
        bus.i_dram_addr[16*k +: 16] = a;
        bus.i_dram_wdata[8*k +: 8]  = d;
    endtask

    task automatic clr_req(input int k);
        set_req(k, 2'b00, 2'b00, 16'h0, 8'h0);
    endtask

    task automatic load(input logic [15:0] a, input logic [7:0] d);
        load_en   = 1'b1;
        load_addr = a;
        load_data = d;
        tick;
        load_en   = 1'b0;
    endtask

    task automatic do_reset;
        rst_n = 1'b0;
        tick;
        tick;
        rst_n = 1'b1;
        tick;
    endtask

    // Bounded wait: cyc reaches 12 when no pulse ever arrives
    task automatic wait_ready(output int cyc);
        cyc = 0;
        do begin
            tick;
            cyc++;
        end while (bus.o_ready == 4'b0 && cyc < 12);
    endtask

    task automatic test_reset;
        do_reset;
        vectors++; if (bus.o_ready !== 4'b0) begin miscompares++; $display("FAIL reset_ready: got %b want 0000", bus.o_ready); end
        vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL reset_busy: got %b want 0", busy); end
        vectors++; if (err !== 1'b0) begin miscompares++; $display("FAIL reset_err: got %b want 0", err); end
        vectors++; if (bus.o_dram_rdata !== 32'h0) begin miscompares++; $display("FAIL reset_rdata: got %h want 00000000", bus.o_dram_rdata); end
    endtask

    task automatic test_preload_read;
        load(16'h0010, 8'h5A);
        set_req(1, 2'b01, 2'b00, 16'h0010, 8'h00);
        tick;
        vectors++; if (busy !== 1'b1) begin miscompares++; $display("FAIL pr_busy_access: got %b want 1", busy); end
        vectors++; if (bus.o_ready !== 4'b0000) begin miscompares++; $display("FAIL pr_ready_early: got %b want 0000", bus.o_ready); end
        tick;
        vectors++; if (bus.o_ready !== 4'b0010) begin miscompares++; $display("FAIL pr_ready_done: got %b want 0010", bus.o_ready); end
        vectors++; if (bus.o_dram_rdata[15:8] !== 8'h5A) begin miscompares++; $display("FAIL pr_rdata1: got %h want 5a", bus.o_dram_rdata[15:8]); end
        clr_req(1);
        tick;
        vectors++; if (bus.o_ready !== 4'b0000) begin miscompares++; $display("FAIL pr_ready_pulse: got %b want 0000", bus.o_ready); end
        vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL pr_busy_idle: got %b want 0", busy); end
        vectors++; if (bus.o_dram_rdata[15:8] !== 8'h5A) begin miscompares++; $display("FAIL pr_rdata1_hold: got %h want 5a", bus.o_dram_rdata[15:8]); end
    endtask

    task automatic test_round_robin;
        int       cyc;
        logic     first;
        logic [3:0] mask;
        for (int k = 0; k < 4; k++) load(16'(16'h0100 + k), 8'(8'hA0 + k));
        do_reset;
        for (int r = 0; r < 2; r++) begin
            mask  = (r == 0) ? 4'b1101 : 4'b1111;
            first = 1'b1;
            for (int k = 0; k < 4; k++) if (mask[k]) set_req(k, 2'b01, 2'b00, 16'(16'h0100 + k), 8'h00);
            for (int k = 0; k < 4; k++) begin
                if (mask[k]) begin
                    wait_ready(cyc);
                    vectors++; if (bus.o_ready !== 4'(1 << k)) begin miscompares++; $display("FAIL rr%0d_order core%0d: got %b want %b", r, k, bus.o_ready, 4'(1 << k)); end
                    vectors++; if (cyc != (first ? 2 : 3)) begin miscompares++; $display("FAIL rr%0d_spacing core%0d: got %0d want %0d", r, k, cyc, first ? 2 : 3); end
                    vectors++; if (bus.o_dram_rdata[8*k +: 8] !== 8'(8'hA0 + k)) begin miscompares++; $display("FAIL rr%0d_rdata core%0d: got %h want %h", r, k, bus.o_dram_rdata[8*k +: 8], 8'(8'hA0 + k)); end
                    clr_req(k);
                    first = 1'b0;
                end
            end
            tick;
        end
    endtask

    task automatic test_write_wrap;
        int cyc;
        set_req(2, 2'b00, 2'b01, 16'h1FFF, 8'hC3);
        wait_ready(cyc);
        vectors++; if (bus.o_ready !== 4'b0100) begin miscompares++; $display("FAIL ww_ready2: got %b want 0100", bus.o_ready); end
        vectors++; if (bus.o_dram_rdata[23:16] !== 8'hA2) begin miscompares++; $display("FAIL ww_rdata2_kept: got %h want a2", bus.o_dram_rdata[23:16]); end
        clr_req(2);
        tick;
        set_req(0, 2'b01, 2'b00, 16'h0FFF, 8'h00);
        wait_ready(cyc);
        vectors++; if (bus.o_ready !== 4'b0001) begin miscompares++; $display("FAIL ww_ready0: got %b want 0001", bus.o_ready); end
        vectors++; if (bus.o_dram_rdata[7:0] !== 8'hC3) begin miscompares++; $display("FAIL ww_rdata0: got %h want c3", bus.o_dram_rdata[7:0]); end
        clr_req(0);
        tick;
    endtask

    task automatic test_illegal_load;
        vectors++; if (err !== 1'b0) begin miscompares++; $display("FAIL il_err_before: got %b want 0", err); end
        set_req(3, 2'b10, 2'b00, 16'h0103, 8'h00);
        tick;
        vectors++; if (err !== 1'b1) begin miscompares++; $display("FAIL il_err_set: got %b want 1", err); end
        vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL il_busy: got %b want 0", busy); end
        tick;
        tick;
        vectors++; if (bus.o_ready !== 4'b0000) begin miscompares++; $display("FAIL il_no_ready: got %b want 0000", bus.o_ready); end
        clr_req(3);
        tick;
        vectors++; if (err !== 1'b1) begin miscompares++; $display("FAIL il_err_sticky: got %b want 1", err); end
        load_en   = 1'b1;
        load_addr = 16'h0200;
        load_data = 8'h3C;
        set_req(0, 2'b01, 2'b00, 16'h0200, 8'h00);
        tick;
        load_en = 1'b0;
        vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL lp_load_first: got busy %b want 0", busy); end
        tick;
        vectors++; if (busy !== 1'b1) begin miscompares++; $display("FAIL lp_grant_next: got busy %b want 1", busy); end
        tick;
        vectors++; if (bus.o_ready !== 4'b0001) begin miscompares++; $display("FAIL lp_ready0: got %b want 0001", bus.o_ready); end
        vectors++; if (bus.o_dram_rdata[7:0] !== 8'h3C) begin miscompares++; $display("FAIL lp_rdata0: got %h want 3c", bus.o_dram_rdata[7:0]); end
        clr_req(0);
        tick;
    endtask

    task automatic test_reset_mid_access;
        int cyc;
        load(16'h0020, 8'h11);
        set_req(1, 2'b00, 2'b01, 16'h0020, 8'h77);
        tick;
        vectors++; if (busy !== 1'b1) begin miscompares++; $display("FAIL rm_in_access: got busy %b want 1", busy); end
        #2 rst_n = 1'b0;
        #1;
        vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL rm_async_busy: got %b want 0", busy); end
        clr_req(1);
        tick;
        vectors++; if (bus.o_ready !== 4'b0000) begin miscompares++; $display("FAIL rm_no_ready: got %b want 0000", bus.o_ready); end
        rst_n = 1'b1;
        tick;
        vectors++; if (err !== 1'b0) begin miscompares++; $display("FAIL rm_err_cleared: got %b want 0", err); end
        set_req(1, 2'b01, 2'b00, 16'h0020, 8'h00);
        wait_ready(cyc);
        vectors++; if (bus.o_ready !== 4'b0010) begin miscompares++; $display("FAIL rm_ready1: got %b want 0010", bus.o_ready); end
        vectors++; if (bus.o_dram_rdata[15:8] !== 8'h11) begin miscompares++; $display("FAIL rm_mem_kept: got %h want 11", bus.o_dram_rdata[15:8]); end
        clr_req(1);
        tick;
    endtask

    initial begin
        load_en          = 1'b0;
        load_addr        = 16'h0;
        load_data        = 8'h0;
        bus.i_dram_read  = '0;
        bus.i_dram_write = '0;
        bus.i_dram_addr  = '0;
        bus.i_dram_wdata = '0;
        test_reset;
        test_preload_read;
        test_round_robin;
        test_write_wrap;
        test_illegal_load;
        test_reset_mid_access;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
